// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared widths, mixer state type and saturation helper
package synth_pkg;

    localparam int SAMPLE_W_DEF = 24;
    localparam int GAIN_W_DEF   = 8;
    localparam int SAT_IN_W     = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCALE
    } mix_state_t;

    // Clamp a wide signed value into the signed range of 'width' bits.
    function automatic logic signed [SAT_IN_W-1:0] saturate(
        input logic signed [SAT_IN_W-1:0] value,
        input int                         width
    );
        logic signed [SAT_IN_W-1:0] max_v;
        logic signed [SAT_IN_W-1:0] min_v;
        logic signed [SAT_IN_W-1:0] result;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            result = max_v;
        end else if (value < min_v) begin
            result = min_v;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/voice_mac.sv
// rtl/voice_mac.sv - registered signed-by-unsigned multiply-accumulate slice
module voice_mac #(
    parameter int SAMPLE_W = 24,
    parameter int GAIN_W   = 8,
    parameter int ACC_W    = 36
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic        [GAIN_W-1:0]   gain,
    input  logic                       voice_en,
    output logic signed [ACC_W-1:0]    acc
);

    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    // Gain is zero-extended so it always acts as a non-negative multiplier.
    always_comb begin
        sample_ext = PROD_W'(sample);
        gain_ext   = PROD_W'($signed({1'b0, gain}));
        product    = voice_en ? (sample_ext * gain_ext) : '0;
        acc_d      = acc_q + ACC_W'(product);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/poly_mixer.sv
// rtl/poly_mixer.sv - N-voice sequential MAC mixer with master volume and saturation
module poly_mixer
    import synth_pkg::*;
#(
    parameter int N_VOICES = 8,
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int GAIN_W   = GAIN_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_strobe,
    input  logic [N_VOICES*SAMPLE_W-1:0] voice_samples,
    input  logic [N_VOICES*GAIN_W-1:0]   voice_gain,
    input  logic [N_VOICES-1:0]          voice_enable,
    input  logic [7:0]                   master_vol,
    output logic [SAMPLE_W-1:0]          mixed_sample,
    output logic                         mixed_valid,
    output logic                         clip,
    output logic                         busy,
    output logic                         overrun
);

    localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int ACC_W = SAMPLE_W + GAIN_W + 1 + $clog2(N_VOICES);
    localparam int SCL_W = ACC_W + 9;
    localparam int SHIFT = GAIN_W + 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

    mix_state_t                   state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [N_VOICES*SAMPLE_W-1:0] samples_q;
    logic [N_VOICES*GAIN_W-1:0]   gain_q;
    logic [N_VOICES-1:0]          enable_q;
    logic [7:0]                   vol_q;
    logic [SAMPLE_W-1:0]          mixed_q, mixed_d;
    logic                         valid_q, valid_d;
    logic                         clip_q, clip_d;
    logic                         overrun_q, overrun_d;
    logic                         accept;

    logic signed [SAMPLE_W-1:0]   cur_sample;
    logic [GAIN_W-1:0]            cur_gain;
    logic                         cur_en;
    logic signed [ACC_W-1:0]      acc;
    logic signed [SCL_W-1:0]      scaled;
    logic signed [SAT_IN_W-1:0]   scaled_ext;
    logic signed [SAT_IN_W-1:0]   sat_val;

    always_comb accept = (state_q == IDLE) && sample_strobe;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (sample_strobe) begin
                    state_d = ACCUM;
                    idx_d   = '0;
                end
            end
            ACCUM: begin
                if (idx_q == LAST_IDX) begin
                    state_d = SCALE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SCALE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Voices are fed to the MAC from the snapshot, one per ACCUM cycle.
    always_comb begin
        cur_sample = samples_q[idx_q*SAMPLE_W +: SAMPLE_W];
        cur_gain   = gain_q[idx_q*GAIN_W +: GAIN_W];
        cur_en     = enable_q[idx_q];
    end

    voice_mac #(
        .SAMPLE_W (SAMPLE_W),
        .GAIN_W   (GAIN_W),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .en       (state_q == ACCUM),
        .sample   (cur_sample),
        .gain     (cur_gain),
        .voice_en (cur_en),
        .acc      (acc)
    );

    // Arithmetic shift floors toward -inf, so small negative mixes land on -1.
    always_comb begin
        scaled     = SCL_W'(acc) * SCL_W'($signed({1'b0, vol_q}));
        scaled_ext = SAT_IN_W'(scaled >>> SHIFT);
        sat_val    = saturate(scaled_ext, SAMPLE_W);
        valid_d    = (state_q == SCALE);
        clip_d     = (state_q == SCALE) && (sat_val != scaled_ext);
        mixed_d    = (state_q == SCALE) ? SAMPLE_W'(sat_val) : mixed_q;
        overrun_d  = sample_strobe && (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            samples_q <= '0;
            gain_q    <= '0;
            enable_q  <= '0;
            vol_q     <= '0;
            mixed_q   <= '0;
            valid_q   <= 1'b0;
            clip_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mixed_q   <= mixed_d;
            valid_q   <= valid_d;
            clip_q    <= clip_d;
            overrun_q <= overrun_d;
            if (accept) begin
                samples_q <= voice_samples;
                gain_q    <= voice_gain;
                enable_q  <= voice_enable;
                vol_q     <= master_vol;
            end
        end
    end

    assign mixed_sample = mixed_q;
    assign mixed_valid  = valid_q;
    assign clip         = clip_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_poly_mixer.sv
// tb/tb_poly_mixer.sv - scoreboard bench for poly_mixer at N_VOICES 8, 1 and 16
module tb_poly_mixer;

    localparam int NDUT = 3;

    typedef struct {
        logic [23:0] val;
        logic        clip;
        int          cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [16*24-1:0]  s_all  [NDUT];
    logic [127:0]      g_all  [NDUT];
    logic [15:0]       en_all [NDUT];
    logic [7:0]        mvol   [NDUT];
    logic              strobe [NDUT];
    logic [23:0]       m_smp  [NDUT];
    logic              m_vld  [NDUT];
    logic              m_clip [NDUT];
    logic              m_busy [NDUT];
    logic              m_ovr  [NDUT];

    exp_t exp_q [NDUT][$];
    int   ovq   [NDUT][$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int   smp [16];
    int   gn  [16];
    bit   en  [16];
    int   mv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    poly_mixer #(.N_VOICES(8)) dut8 (
        .clk(clk), .reset(reset), .sample_strobe(strobe[0]),
        .voice_samples(s_all[0][8*24-1:0]), .voice_gain(g_all[0][63:0]),
        .voice_enable(en_all[0][7:0]), .master_vol(mvol[0]),
        .mixed_sample(m_smp[0]), .mixed_valid(m_vld[0]), .clip(m_clip[0]),
        .busy(m_busy[0]), .overrun(m_ovr[0])
    );

    poly_mixer #(.N_VOICES(1)) dut1 (
        .clk(clk), .reset(reset), .sample_strobe(strobe[1]),
        .voice_samples(s_all[1][23:0]), .voice_gain(g_all[1][7:0]),
        .voice_enable(en_all[1][0:0]), .master_vol(mvol[1]),
        .mixed_sample(m_smp[1]), .mixed_valid(m_vld[1]), .clip(m_clip[1]),
        .busy(m_busy[1]), .overrun(m_ovr[1])
    );

    poly_mixer #(.N_VOICES(16)) dut16 (
        .clk(clk), .reset(reset), .sample_strobe(strobe[2]),
        .voice_samples(s_all[2]), .voice_gain(g_all[2]),
        .voice_enable(en_all[2]), .master_vol(mvol[2]),
        .mixed_sample(m_smp[2]), .mixed_valid(m_vld[2]), .clip(m_clip[2]),
        .busy(m_busy[2]), .overrun(m_ovr[2])
    );

    function automatic int nv(input int d);
        return (d == 0) ? 8 : ((d == 1) ? 1 : 16);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    // Reference: plain integer sum of sample*gain, volume, floor divide, clamp.
    function automatic void model(input int n, output logic [23:0] val, output logic clp);
        longint acc = 0;
        longint sc;
        for (int i = 0; i < n; i++)
            if (en[i]) acc += longint'(smp[i]) * longint'(gn[i]);
        sc = (acc * longint'(mv)) >>> 16;
        clp = 1'b0;
        if (sc > 64'sd8388607) begin
            sc = 64'sd8388607;
            clp = 1'b1;
        end else if (sc < -64'sd8388608) begin
            sc = -64'sd8388608;
            clp = 1'b1;
        end
        val = sc[23:0];
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_stim();
        for (int i = 0; i < 16; i++) begin
            smp[i] = 0;
            gn[i]  = 0;
            en[i]  = 1'b0;
        end
        mv = 0;
    endtask

    task automatic scramble(input int d);
        for (int i = 0; i < 12; i++) s_all[d][i*32 +: 32] = $urandom;
        g_all[d]  = {$urandom, $urandom, $urandom, $urandom};
        en_all[d] = 16'($urandom);
        mvol[d]   = 8'($urandom);
    endtask

    task automatic issue(input int d, input bit push, output int t);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            s_all[d][i*24 +: 24] = smp[i][23:0];
            g_all[d][i*8 +: 8]   = gn[i][7:0];
            en_all[d][i]         = en[i];
        end
        mvol[d] = mv[7:0];
        model(nv(d), e.val, e.clip);
        t     = cyc;
        e.cyc = cyc + nv(d) + 2;
        if (push) exp_q[d].push_back(e);
        strobe[d] = 1'b1;
        wait_cycles(1);
        strobe[d] = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < NDUT; d++) begin
            if (m_vld[d]) begin
                if (exp_q[d].size() == 0) begin
                    chk($sformatf("unexpected_valid_d%0d", d), 32'd1, 32'd0);
                end else begin
                    e = exp_q[d].pop_front();
                    chk($sformatf("sample_d%0d", d), 32'(m_smp[d]), 32'(e.val));
                    chk($sformatf("clip_d%0d", d), 32'(m_clip[d]), 32'(e.clip));
                    chk($sformatf("latency_d%0d", d), cyc, e.cyc);
                end
            end else if (m_clip[d]) begin
                chk($sformatf("clip_without_valid_d%0d", d), 32'd1, 32'd0);
            end
            if (m_ovr[d]) ovq[d].push_back(cyc);
        end
    end

    initial begin
        int t;
        int t2;
        logic [23:0] r;
        for (int d = 0; d < NDUT; d++) begin
            s_all[d] = '0; g_all[d] = '0; en_all[d] = '0; mvol[d] = '0; strobe[d] = 1'b0;
        end
        clr_stim();
        wait_cycles(4);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("rst_sample_d%0d", d), 32'(m_smp[d]), 32'd0);
            chk($sformatf("rst_valid_d%0d", d), 32'(m_vld[d]), 32'd0);
            chk($sformatf("rst_busy_d%0d", d), 32'(m_busy[d]), 32'd0);
            chk($sformatf("rst_clip_d%0d", d), 32'(m_clip[d]), 32'd0);
            chk($sformatf("rst_overrun_d%0d", d), 32'(m_ovr[d]), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        wait_cycles(2);

        // Basic latency and busy window.
        clr_stim();
        smp[0] = 32'h100000; gn[0] = 128; en[0] = 1'b1; mv = 255;
        issue(0, 1'b1, t);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk($sformatf("busy_t%0d", i), 32'(m_busy[0]), 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("busy_done", 32'(m_busy[0]), 32'd0);
        @(posedge clk); #1;
        wait_cycles(2);

        clr_stim();
        for (int i = 0; i < 8; i++) begin smp[i] = 8388607; gn[i] = 255; en[i] = 1'b1; end
        mv = 255;
        issue(0, 1'b1, t); wait_cycles(11);
        for (int i = 0; i < 8; i++) smp[i] = -8388608;
        issue(0, 1'b1, t); wait_cycles(11);

        clr_stim();
        for (int i = 0; i < 8; i++) smp[i] = 32'h400000;
        smp[2] = -1; gn[2] = 255; en[2] = 1'b1; mv = 255;
        for (int i = 0; i < 8; i++) if (i != 2) gn[i] = 200;
        issue(0, 1'b1, t); wait_cycles(11);

        // Overrun with input change after the snapshot, then a strobe in the valid cycle.
        ovq[0].delete();
        clr_stim();
        for (int i = 0; i < 8; i++) begin smp[i] = 1000 * (i + 1) - 4000; gn[i] = 17 * i + 3; en[i] = (i % 3) != 0; end
        mv = 200;
        issue(0, 1'b1, t);
        scramble(0);
        wait_cycles(2);
        strobe[0] = 1'b1;
        wait_cycles(1);
        strobe[0] = 1'b0;
        wait_cycles(6);
        smp[1] = 77777; gn[1] = 99; en[1] = 1'b1;
        issue(0, 1'b1, t2);
        wait_cycles(10);
        chk("overrun_count", 32'(ovq[0].size()), 32'd1);
        if (ovq[0].size() > 0) chk("overrun_cycle", ovq[0][0], t + 4);

        // Reset during ACCUM aborts the mix.
        issue(0, 1'b0, t);
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(m_vld[0]), 32'd0);
        chk("abort_sample", 32'(m_smp[0]), 32'd0);
        chk("abort_busy", 32'(m_busy[0]), 32'd0);
        @(posedge clk); #1;
        wait_cycles(6);
        clr_stim();
        smp[3] = -300000; gn[3] = 90; en[3] = 1'b1; mv = 128;
        issue(0, 1'b1, t); wait_cycles(11);

        // Randomised sweep, back-to-back strobes in each valid cycle.
        for (int d = 0; d < NDUT; d++) begin
            repeat (25) begin
                for (int i = 0; i < 16; i++) begin
                    r = 24'($urandom);
                    smp[i] = int'($signed(r));
                    case ($urandom_range(0, 5))
                        0: smp[i] = 8388607;
                        1: smp[i] = -8388608;
                        default: ;
                    endcase
                    gn[i] = $urandom_range(0, 255);
                    en[i] = 1'($urandom_range(0, 1));
                end
                mv = $urandom_range(0, 255);
                issue(d, 1'b1, t);
                scramble(d);
                wait_cycles(nv(d) + 1);
            end
            wait_cycles(nv(d) + 4);
        end

        wait_cycles(30);
        for (int d = 0; d < NDUT; d++)
            chk($sformatf("pending_d%0d", d), 32'(exp_q[d].size()), 32'd0);
        chk("overrun_d1", 32'(ovq[1].size()), 32'd0);
        chk("overrun_d2", 32'(ovq[2].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/poly_mixer.md
Name: poly_mixer

Overview:
Parametrised N-voice sample mixer that generalises the fixed 4-input mixer.
- On each sample strobe it snapshots all voice samples, then multiply-accumulates one voice per clock using a per-voice gain and enable mask.
- It then applies master volume and saturates to the output width.
- It sits between the waveform_generator bank and I2S_interface; the strobe is derived from the I2S frame clock.

Parameters:
N_VOICES, 8, number of voice inputs (>=1)
SAMPLE_W, 24, signed two's-complement sample width, input and output
GAIN_W, 8, unsigned per-voice gain width; gain g means g/2^GAIN_W

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high reset
sample_strobe  input  1  single-cycle request to start a mix
voice_samples  input  N_VOICES*SAMPLE_W  packed signed samples; voice i occupies bits [i*SAMPLE_W +: SAMPLE_W]
voice_gain  input  N_VOICES*GAIN_W  packed unsigned gains; voice i occupies [i*GAIN_W +: GAIN_W]
voice_enable  input  N_VOICES  per-voice enable; 0 contributes zero
master_vol  input  8  unsigned master volume; v means v/256
mixed_sample  output  SAMPLE_W  signed mixed result; held between updates
mixed_valid  output  1  one-cycle pulse when mixed_sample updates
clip  output  1  one-cycle pulse coincident with mixed_valid when the result saturated
busy  output  1  high while a mix is in progress
overrun  output  1  one-cycle pulse when a strobe is dropped

Behaviour:
- Reset values (synchronous, active-high): all outputs 0, state IDLE, voice counter 0, accumulator 0.
- States:
  - IDLE: busy=0. sample_strobe=1 registers a snapshot of voice_samples, voice_gain, voice_enable and master_vol, clears the accumulator and voice index, then moves to ACCUM.
  - ACCUM: for N_VOICES cycles, voice index k=0..N_VOICES-1, acc += enable[k] ? sample[k]*gain[k] : 0.
    - Product: signed × zero-extended unsigned, SAMPLE_W+GAIN_W+1 bits.
    - Accumulator width: ACC_W = SAMPLE_W+GAIN_W+1+$clog2(N_VOICES); no overflow is possible.
    - Moves to SCALE after index N_VOICES-1.
  - SCALE: scaled = (acc * {1'b0,master_vol}) >>> (GAIN_W+8), using an arithmetic shift (floor toward -inf).
    - Saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
    - At the next edge: register mixed_sample, pulse mixed_valid, pulse clip if saturated, return to IDLE.
- Latency: strobe sampled in cycle t -> mixed_valid high in cycle t+N_VOICES+2.
- Inputs may change freely after the strobe cycle; only the snapshot is used.
- Strobe in ACCUM or SCALE: ignored; overrun pulses in the following cycle; the in-flight mix completes unaffected.
- Strobe in the cycle mixed_valid is high: the state is already IDLE, so the strobe is accepted.
- Strobe throughput: at most one accepted strobe per N_VOICES+2 cycles.
- busy = (state != IDLE).
- Reset mid-operation: the mix is aborted, no mixed_valid is produced, mixed_sample returns to 0.
- Unity gain is unreachable by design (max 255/256); there is no special case.
- N_VOICES=1 is legal: ACCUM lasts one cycle.

Decomposition:
- Package synth_pkg holds:
  - the SAMPLE_W and GAIN_W defaults
  - the mix_state_t enum {IDLE, ACCUM, SCALE}
  - the function saturate(value, width) used by the mixer and future effects blocks
- Optional sub-module voice_mac: registered multiply-accumulate slice (sample, gain, enable, clear) -> acc. This isolates the DSP-block inference.
- All other logic stays in poly_mixer.

Test Plan:
- Latency/basic: N=8; only voice 0 enabled, sample 0x100000, gain 128, master 255; strobe at t -> mixed_sample 0x07F800 and mixed_valid at t+10, clip=0, busy high t+1..t+9.
- Positive saturation: all 8 voices 0x7FFFFF, gain 255, master 255 -> 0x7FFFFF with clip=1. Negative: all 0x800000 -> 0x800000 with clip=1.
- Floor rounding/enable: voice 2 sample 0xFFFFFF (-1), gain 255, master 255, others sample 0x400000 but disabled -> 0xFFFFFF, clip=0.
- Overrun/snapshot: strobe at t and t+3, change voice_samples at t+1 -> overrun pulse at t+4, exactly one mixed_valid at t+10 with the t-snapshot result. Strobe at t+10 is accepted with valid at t+20.
- Reset mid-mix: strobe at t, reset at t+4 -> no mixed_valid, mixed_sample=0, busy=0 from t+5; next strobe produces a normal result.
- Parameter sweep: N_VOICES=1 and 16 with random samples/gains/masks vs a reference model -> bit-exact, latency N_VOICES+2.
